module_bin_to_bcd_seq: RTL and testbench

Parametrised, sequential double-dabble converter. It turns a BIN_W-bit binary value into DIGITS packed BCD digits, doing one shift/add-3 iteration per clock.
- Adds a signed (two's-complement) mode, per-digit leading-zero blanking, and valid/ready handshakes on both sides.
- Sits between the datapath/ALU result registers and the 7-segment display driver. It replaces the combinational converter where BIN_W is large or timing is tight.

---
 rtl/bcd_pkg.sv | 9 +
 rtl/module_bcd_add3.sv | 7 +
 rtl/module_bin_to_bcd_seq.sv | 89 ++++++++
 tb/tb_module_bin_to_bcd_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states and digit-count helper for the binary-to-BCD converter
package bcd_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
   function automatic int bcd_digits_for(input int width);
      int d = 0;
      for (longint unsigned m = (64'd1 << width) - 64'd1; m != 0; m = m / 10) d++;
      return d;
   endfunction
endpackage

// File: rtl/module_bcd_add3.sv
// module_bcd_add3: double-dabble digit correction, adds 3 when the digit exceeds 4
module module_bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = d > 4'd4 ? d + 4'd3 : d;
endmodule

// File: rtl/module_bin_to_bcd_seq.sv
// module_bin_to_bcd_seq: one-iteration-per-clock double-dabble converter with sign and blanking
module module_bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [BIN_W-1:0]      i_bin,
   input  logic                  i_signed,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_neg,
   output logic [DIGITS-1:0]     o_blank
);
   localparam int CNT_W = $clog2(BIN_W);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);
   if (BIN_W < 2 || DIGITS < bcd_digits_for(BIN_W)) begin : g_bad_params
      $error("module_bin_to_bcd_seq: DIGITS too small for BIN_W");
   end
   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BIN_W-1:0]  bin_sr, bin_n, mag;
   logic [BCD_W-1:0]  acc, adj, acc_n;
   logic              neg, neg_in, z;
   logic [DIGITS-1:0] blank_n;
   assign neg_in = i_signed & i_bin[BIN_W-1];
   assign mag    = neg_in ? ~i_bin + 1'b1 : i_bin;
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      module_bcd_add3 u_add3 (.d(acc[4*g +: 4]), .q(adj[4*g +: 4]));
   end
   assign {acc_n, bin_n} = {adj, bin_sr} << 1;
   always_comb begin
      blank_n = '0;
      z = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         z = z & (acc_n[4*d +: 4] == 4'd0);
         blank_n[d] = z;
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_IDLE;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_bcd   <= '0;
         o_neg   <= 1'b0;
         o_blank <= BLANK_RST;
         cnt     <= '0;
         bin_sr  <= '0;
         acc     <= '0;
         neg     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (i_valid) begin
               bin_sr  <= mag;
               neg     <= neg_in;
               acc     <= '0;
               cnt     <= '0;
               o_ready <= 1'b0;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               acc    <= acc_n;
               bin_sr <= bin_n;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  state   <= S_DONE;
                  o_valid <= 1'b1;
                  o_bcd   <= acc_n;
                  o_neg   <= neg & (acc_n != '0);
                  o_blank <= blank_n;
               end
            end
            S_DONE: if (i_ready) begin
               state   <= S_IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_module_bin_to_bcd_seq.sv
// tb_module_bin_to_bcd_seq: directed and swept checks of the sequential BCD converter
module tb_module_bin_to_bcd_seq;
   logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
   logic a_valid = 1'b0, a_ready, a_sgn = 1'b0, a_ovalid, a_iready = 1'b0, a_neg;
   logic [11:0] a_bin = '0;
   logic [15:0] a_bcd;
   logic [3:0]  a_blank;
   logic b_valid = 1'b0, b_ready, b_sgn = 1'b0, b_ovalid, b_iready = 1'b0, b_neg;
   logic [15:0] b_bin = '0;
   logic [19:0] b_bcd;
   logic [4:0]  b_blank;
   logic s_rdy, s_ovalid, s_neg;
   logic [19:0] s_bcd;
   logic [4:0]  s_blank;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   module_bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) u_a (
      .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready), .i_bin(a_bin),
      .i_signed(a_sgn), .o_valid(a_ovalid), .i_ready(a_iready), .o_bcd(a_bcd),
      .o_neg(a_neg), .o_blank(a_blank));
   module_bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_b (
      .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_bin(b_bin),
      .i_signed(b_sgn), .o_valid(b_ovalid), .i_ready(b_iready), .o_bcd(b_bcd),
      .o_neg(b_neg), .o_blank(b_blank));
   always_comb begin
      s_rdy    = sel ? b_ready  : a_ready;
      s_ovalid = sel ? b_ovalid : a_ovalid;
      s_neg    = sel ? b_neg    : a_neg;
      s_bcd    = sel ? b_bcd    : {4'h0, a_bcd};
      s_blank  = sel ? b_blank  : {1'b0, a_blank};
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [19:0] ref_bcd(input int unsigned v);
      logic [19:0] r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction
   function automatic logic [4:0] ref_blank(input logic [19:0] bcd, input int digits);
      logic [4:0] r = '0;
      logic zz = 1'b1;
      for (int d = digits - 1; d >= 1; d--) begin
         zz = zz & (bcd[4*d +: 4] == 4'd0);
         r[d] = zz;
      end
      return r;
   endfunction
   task automatic run(input logic sb, input logic [15:0] bin, input logic sgn, input int hold);
      int w = sb ? 16 : 12;
      int unsigned v = int'(bin) & ((1 << w) - 1);
      logic ng = sgn && ((v >> (w - 1)) & 1) == 1;
      int unsigned mag = ng ? (1 << w) - v : v;
      logic [19:0] eb = ref_bcd(mag);
      int n = 0;
      sel = sb;
      @(negedge clk);
      check("ready_idle", 32'(s_rdy), 1);
      if (sb) begin b_bin = bin; b_sgn = sgn; b_valid = 1'b1; end
      else begin a_bin = bin[11:0]; a_sgn = sgn; a_valid = 1'b1; end
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      while (!s_ovalid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, w);
      check("bcd", 32'(s_bcd), 32'(eb));
      check("neg", 32'(s_neg), 32'(ng && mag != 0));
      check("blank", 32'(s_blank), 32'(ref_blank(eb, sb ? 5 : 4)));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(s_ovalid), 1);
         check("hold_ready", 32'(s_rdy), 0);
         check("hold_bcd", 32'(s_bcd), 32'(eb));
      end
      if (sb) b_iready = 1'b1; else a_iready = 1'b1;
      @(negedge clk);
      a_iready = 1'b0;
      b_iready = 1'b0;
      check("post_valid", 32'(s_ovalid), 0);
      check("post_ready", 32'(s_rdy), 1);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(a_ready), 1);
      check("rst_valid", 32'(a_ovalid), 0);
      check("rst_bcd", 32'(a_bcd), 0);
      check("rst_neg", 32'(a_neg), 0);
      check("rst_blank_a", 32'(a_blank), 32'h0e);
      check("rst_blank_b", 32'(b_blank), 32'h1e);
      rst = 1'b0;
      run(1'b0, 16'd4095, 1'b0, 0);
      run(1'b0, 16'd0, 1'b0, 0);
      run(1'b0, 16'd7, 1'b0, 0);
      run(1'b0, 16'h800, 1'b1, 0);
      run(1'b0, 16'hfff, 1'b1, 0);
      run(1'b0, 16'h7ff, 1'b1, 0);
      run(1'b0, 16'hfff, 1'b0, 0);
      run(1'b0, 16'd3000, 1'b0, 20);
      sel = 1'b0;
      @(negedge clk);
      a_bin = 12'd1234;
      a_sgn = 1'b0;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(a_ovalid), 0);
      check("midrst_ready", 32'(a_ready), 1);
      check("midrst_bcd", 32'(a_bcd), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("no_pulse", 32'(a_ovalid), 0);
      run(1'b0, 16'd56, 1'b0, 0);
      run(1'b1, 16'd65535, 1'b0, 0);
      run(1'b1, 16'h8000, 1'b1, 0);
      run(1'b1, 16'd9, 1'b0, 0);
      for (int i = 0; i < 1000; i++) run(1'(i % 2), 16'($urandom), 1'($urandom), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
